// File: rtl/fifo_pkg.sv
// Constants and pointer helpers shared by both sides of the async FIFO.
// bin2gray is width-agnostic: callers zero-extend to PTR_W_MAX and keep the low bits.
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 3;
  localparam int PTR_W_MAX     = 32;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle: write-pointer input, memory read port and the output handshake.
// master = read controller, slave = memory/consumer side.
interface fifo_read_ctrl_if import fifo_pkg::*; #(
  parameter int data_size    = DATA_SIZE_DEF,
  parameter int address_size = ADDR_SIZE_DEF
);

  logic [address_size:0]   write_ptr_gray;
  logic [data_size-1:0]    read_data;
  logic [address_size-1:0] read_address;
  logic [address_size:0]   read_ptr_gray;
  logic                    read_empty;
  logic [data_size-1:0]    out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  write_ptr_gray, read_data, out_ready,
    output read_address, read_ptr_gray, read_empty, out_data, out_valid
  );

  modport slave (
    output write_ptr_gray, read_data, out_ready,
    input  read_address, read_ptr_gray, read_empty, out_data, out_valid
  );

endinterface

// File: rtl/sync_w2r.sv
// Two-flop synchronizer bringing the Gray write pointer into read_clk.
// Latency 2 read_clk edges; no backpressure.
module sync_w2r import fifo_pkg::*; #(
  parameter int width = ADDR_SIZE_DEF + 1
) (
  input  logic             read_clk,
  input  logic             read_reset_n,
  input  logic [width-1:0] i_wptr_gray,
  output logic [width-1:0] o_wptr_s2
);

  logic [width-1:0] r_wptr_s1;
  logic [width-1:0] r_wptr_s2;

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      r_wptr_s1 <= '0;
      r_wptr_s2 <= '0;
    end else begin
      r_wptr_s1 <= i_wptr_gray;
      r_wptr_s2 <= r_wptr_s1;
    end
  end

  assign o_wptr_s2 = r_wptr_s2;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read controller: Gray pointer, registered empty flag, one-word output register.
// Word appears one edge after pop; out_ready=0 holds the output word and stops popping.
module fifo_read_ctrl import fifo_pkg::*; #(
  parameter int data_size    = DATA_SIZE_DEF,
  parameter int address_size = ADDR_SIZE_DEF
) (
  input  logic             read_clk,
  input  logic             read_reset_n,
  fifo_read_ctrl_if.master bus
);

  logic [address_size:0]  r_read_bin;
  logic [address_size:0]  r_read_gray;
  logic [address_size:0]  w_read_bin_next;
  logic [address_size:0]  w_read_gray_next;
  logic [address_size:0]  w_wptr_s2;
  logic [PTR_W_MAX-1:0]   w_gray_full;
  logic                   r_read_empty;
  logic                   r_out_valid;
  logic [data_size-1:0]   r_out_data;
  logic                   w_pop;

  sync_w2r #(.width(address_size + 1)) u_sync_w2r (
    .read_clk     (read_clk),
    .read_reset_n (read_reset_n),
    .i_wptr_gray  (bus.write_ptr_gray),
    .o_wptr_s2    (w_wptr_s2)
  );

  // Pop refills the output register whenever it is empty or being drained this cycle.
  assign w_pop            = !r_read_empty && (!r_out_valid || bus.out_ready);
  assign w_read_bin_next  = r_read_bin + (address_size + 1)'(w_pop);
  assign w_gray_full      = bin2gray(PTR_W_MAX'(w_read_bin_next));
  assign w_read_gray_next = w_gray_full[address_size:0];

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      r_read_bin   <= '0;
      r_read_gray  <= '0;
      r_read_empty <= 1'b1;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_read_bin   <= w_read_bin_next;
      r_read_gray  <= w_read_gray_next;
      // Full-width Gray compare: the extra MSB separates wrapped-full from empty.
      r_read_empty <= (w_gray_full == PTR_W_MAX'(w_wptr_s2));
      if (w_pop) begin
        r_out_data  <= bus.read_data;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.read_address  = r_read_bin[address_size-1:0];
  assign bus.read_ptr_gray = r_read_gray;
  assign bus.read_empty    = r_read_empty;
  assign bus.out_data      = r_out_data;
  assign bus.out_valid     = r_out_valid;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: the write side and memory are modelled here.
module tb_fifo_read_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] mem [8];
  logic [3:0] wr_bin;
  int         checks = 0;
  int         errors = 0;

  fifo_read_ctrl_if #(.data_size(8), .address_size(3)) bus ();

  fifo_read_ctrl #(.data_size(8), .address_size(3)) dut (
    .read_clk     (clk),
    .read_reset_n (rst_n),
    .bus          (bus.master)
  );

  assign bus.read_data = mem[bus.read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_bin[2:0]]   = d;
    wr_bin             = wr_bin + 4'd1;
    bus.write_ptr_gray = wr_bin ^ (wr_bin >> 1);
  endtask

  task automatic do_reset;
    rst_n              = 1'b0;
    wr_bin             = 4'd0;
    bus.write_ptr_gray = 4'd0;
    bus.out_ready      = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    int         sent;
    int         rcvd;
    int         wraps;
    logic [3:0] pg;
    logic [2:0] pa;

    rst_n              = 1'b1;
    bus.out_ready      = 1'b0;
    wr_bin             = 4'd0;
    bus.write_ptr_gray = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset must act before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", bus.read_empty, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_gray", bus.read_ptr_gray, 0);
    chk("rst_addr", bus.read_address, 0);
    chk("rst_data", bus.out_data, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_empty", bus.read_empty, 1);
    chk("idle_valid", bus.out_valid, 0);

    // Single word: 3 edges to non-empty, 1 more to out_valid.
    push(8'hFF);
    tick;
    chk("sw_empty_e1", bus.read_empty, 1);
    tick;
    chk("sw_empty_e2", bus.read_empty, 1);
    tick;
    chk("sw_empty_e3", bus.read_empty, 0);
    chk("sw_valid_e3", bus.out_valid, 0);
    tick;
    chk("sw_valid", bus.out_valid, 1);
    chk("sw_data", bus.out_data, 8'hFF);
    chk("sw_empty_again", bus.read_empty, 1);
    chk("sw_gray", bus.read_ptr_gray, 4'b0001);
    chk("sw_addr", bus.read_address, 1);
    bus.out_ready = 1'b1;
    tick;
    chk("sw_consumed_valid", bus.out_valid, 0);
    chk("sw_consumed_hold", bus.out_data, 8'hFF);
    bus.out_ready = 1'b0;

    // Backpressure with three words.
    do_reset;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (3) tick;
    chk("bp_empty", bus.read_empty, 0);
    tick;
    chk("bp_first_data", bus.out_data, 8'h11);
    chk("bp_first_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_data", bus.out_data, 8'h11);
      chk("bp_hold_addr", bus.read_address, 1);
      chk("bp_hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick;
    chk("bp_second", bus.out_data, 8'h22);
    chk("bp_second_addr", bus.read_address, 2);
    tick;
    chk("bp_third", bus.out_data, 8'h33);
    chk("bp_third_valid", bus.out_valid, 1);
    chk("bp_last_empty", bus.read_empty, 1);
    tick;
    chk("bp_drained_valid", bus.out_valid, 0);
    chk("bp_drained_hold", bus.out_data, 8'h33);

    // Stream 20 words through the wrap points; read pointer starts at 3.
    sent  = 0;
    rcvd  = 0;
    wraps = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent < 20) begin
        push(8'(sent));
        sent++;
      end
      pg = bus.read_ptr_gray;
      pa = bus.read_address;
      tick;
      chk("wrap_gray_step", 32'($countones(pg ^ bus.read_ptr_gray) <= 1), 1);
      if (pa == 3'd7 && bus.read_address == 3'd0) wraps++;
      if (bus.out_valid) begin
        chk("wrap_data", bus.out_data, rcvd);
        rcvd++;
      end
    end
    chk("wrap_count", rcvd, 20);
    chk("wrap_addr_wraps", wraps, 2);
    chk("wrap_end_empty", bus.read_empty, 1);
    chk("wrap_end_addr", bus.read_address, 7);

    // Mid-stream reset discards the held word.
    bus.out_ready = 1'b0;
    push(8'hA5);
    repeat (4) tick;
    chk("mr_valid", bus.out_valid, 1);
    chk("mr_data", bus.out_data, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", bus.out_valid, 0);
    chk("mr_rst_data", bus.out_data, 0);
    chk("mr_rst_gray", bus.read_ptr_gray, 0);
    chk("mr_rst_addr", bus.read_address, 0);
    chk("mr_rst_empty", bus.read_empty, 1);
    wr_bin             = 4'd0;
    bus.write_ptr_gray = 4'd0;
    tick;
    chk("mr_hold_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("mr_post_empty", bus.read_empty, 1);
    chk("mr_post_valid", bus.out_valid, 0);
    chk("mr_post_addr", bus.read_address, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter data_size, default 8, width of a FIFO word.
REQ-002 SHALL have parameter address_size, default 3, memory address width; depth 2**address_size = 8.
REQ-003 SHALL have port read_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port read_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port write_ptr_gray  input  address_size+1  Gray-coded write pointer from the write domain, asynchronous to read_clk.
REQ-006 SHALL have port read_data  input  data_size  word from FIFO_memory at read_address, combinational.
REQ-007 SHALL have port read_address  output  address_size  memory read address, = read_bin[address_size-1:0].
REQ-008 SHALL have port read_ptr_gray  output  address_size+1  registered Gray read pointer, to the write domain.
REQ-009 SHALL have port read_empty  output  1  registered empty flag.
REQ-010 SHALL have port out_data  output  data_size  popped word held in the output register.
REQ-011 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid=1.

Function
REQ-013 SHALL synchronize write_ptr_gray through two read_clk flops (wptr_s1, wptr_s2); only wptr_s2 is used.
REQ-014 SHALL pop when read_empty=0 and (out_valid=0 or out_ready=1); pop = internal strobe, same cycle.
REQ-015 On pop, SHALL load out_data <= read_data and set out_valid=1 at the next edge.
REQ-016 Without pop, out_ready=1 with out_valid=1 SHALL clear out_valid; out_data SHALL hold its value.
REQ-017 out_valid=1 and out_ready=0 SHALL hold out_data/out_valid unchanged (no overwrite, no pop).
REQ-018 Simultaneous out_ready=1, out_valid=1, read_empty=0 SHALL consume and reload in one cycle; sustained throughput one word per cycle.
REQ-019 read_bin_next SHALL be read_bin + pop, modulo 2**(address_size+1); read_gray_next = (read_bin_next>>1) ^ read_bin_next.
REQ-020 read_bin and read_ptr_gray SHALL register read_bin_next and read_gray_next each cycle.
REQ-021 read_empty SHALL register (read_gray_next == wptr_s2).
REQ-022 Wrap-around: pointer SHALL roll 4'b1111 -> 4'b0000 (address_size=3) with read_address 7 -> 0; empty test remains full-width Gray compare.
REQ-023 Latency: write-pointer change to read_empty deassert SHALL be 3 read_clk edges (2 sync + 1 flag); read_empty deassert to out_valid=1 SHALL be 1 edge.
REQ-024 Pop of the last stored word SHALL assert read_empty at the same edge the word is loaded (no extra read, no underflow).
REQ-025 read_ptr_gray SHALL change at most one bit per cycle.

Reset
REQ-026 read_reset_n=0 SHALL immediately clear read_bin, read_ptr_gray, wptr_s1, wptr_s2, out_data to 0, out_valid to 0, and set read_empty to 1.
REQ-027 Reset asserted mid-stream SHALL discard any held out_data; no pop SHALL occur until read_reset_n=1 and read_empty=0.
REQ-028 Reset deassertion SHALL take effect at the next read_clk edge.

Structure
REQ-029 A shared package fifo_pkg SHALL hold default data_size/address_size constants and the bin-to-Gray conversion function, shared with the write-side controller.
REQ-030 The two-flop synchronizer SHALL be a sub-module sync_w2r (parameter width address_size+1, inputs read_clk/read_reset_n).
REQ-031 Block SHALL contain no memory array; storage stays in FIFO_memory.

Verification
REQ-032 Reset: read_reset_n=0 -> read_empty=1, out_valid=0, read_ptr_gray=0, read_address=0 immediately.
REQ-033 Single word: write_ptr_gray 0->1, memory[0]=8'hFF, out_ready=0 -> read_empty=0 after 3 edges, out_data=8'hFF, out_valid=1 one edge later, read_empty=1 again, read_ptr_gray=4'b0001.
REQ-034 Backpressure: 3 words (8'h11, 8'h22, 8'h33), out_ready=0 for 5 cycles -> out_data stays 8'h11, read_address stays 1; then out_ready=1 -> 8'h22, 8'h33 on consecutive cycles.
REQ-035 Wrap: stream 20 words 0..19 with out_ready=1 -> all received in order, read_address wraps 7->0 twice, read_ptr_gray 1-bit steps.
REQ-036 Mid-stream reset: pulse read_reset_n=0 while out_valid=1 -> out_valid=0, out_data=0 asynchronously; pointers back to 0.
